// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: schedule FSM states, word/round sizes, round constants
// and the one-bit rotate used by the message schedule.
package sha1_pkg;

    localparam int SHA1_WORD_W = 32;
    localparam int SHA1_ROUNDS = 80;

    localparam logic [SHA1_WORD_W-1:0] SHA1_K0 = 32'h5a82_7999;
    localparam logic [SHA1_WORD_W-1:0] SHA1_K1 = 32'h6ed9_eba1;
    localparam logic [SHA1_WORD_W-1:0] SHA1_K2 = 32'h8f1b_bcdc;
    localparam logic [SHA1_WORD_W-1:0] SHA1_K3 = 32'hca62_c1d6;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sha1_state_e;

    function automatic logic [SHA1_WORD_W-1:0] rotl1(input logic [SHA1_WORD_W-1:0] x);
        return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
    endfunction

endpackage

// File: rtl/sha1_wbuf.sv
// 16-entry circular window of the message schedule: one write port and the four
// read taps (p, p-3, p-8, p-14 mod 16) needed to form the next schedule word.
module sha1_wbuf
    import sha1_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [3:0]             waddr_i,
    input  logic [SHA1_WORD_W-1:0] wdata_i,
    input  logic [3:0]             p_i,
    output logic [SHA1_WORD_W-1:0] tap_p_o,
    output logic [SHA1_WORD_W-1:0] tap_p3_o,
    output logic [SHA1_WORD_W-1:0] tap_p8_o,
    output logic [SHA1_WORD_W-1:0] tap_p14_o
);

    logic [SHA1_WORD_W-1:0] mem_q [16];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // 4-bit subtraction wraps, giving the mod-16 tap positions directly.
    assign tap_p_o   = mem_q[p_i];
    assign tap_p3_o  = mem_q[p_i - 4'd3];
    assign tap_p8_o  = mem_q[p_i - 4'd8];
    assign tap_p14_o = mem_q[p_i - 4'd14];

endmodule

// File: rtl/sha1_wsched.sv
// SHA-1 message-schedule source: loads 16 words, then emits W[0]..W[ROUNDS-1]
// one per next handshake, flagging W[0] with feed and the final word with last.
module sha1_wsched
    import sha1_pkg::*;
#(
    parameter int ROUNDS = SHA1_ROUNDS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SHA1_WORD_W-1:0] load_word,
    output logic                   load_ready,
    output logic [SHA1_WORD_W-1:0] w,
    output logic                   w_valid,
    output logic [6:0]             w_index,
    output logic                   feed,
    output logic                   last,
    input  logic                   next,
    output logic                   done,
    output sha1_state_e            state_dbg_o
);

    // Load port: a word moves when load && load_ready at a rising edge.
    // Schedule port: W[t] moves when w_valid && next at a rising edge; w and
    // w_index hold steady while next is low.

    sha1_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [6:0]             t_q, t_d;

    logic                   buf_we;
    logic [3:0]             buf_waddr;
    logic [SHA1_WORD_W-1:0] buf_wdata;
    logic [SHA1_WORD_W-1:0] tap_p, tap_p3, tap_p8, tap_p14;
    logic [SHA1_WORD_W-1:0] w_run;
    logic                   run;

    sha1_wbuf u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .we_i      (buf_we),
        .waddr_i   (buf_waddr),
        .wdata_i   (buf_wdata),
        .p_i       (t_q[3:0]),
        .tap_p_o   (tap_p),
        .tap_p3_o  (tap_p3),
        .tap_p8_o  (tap_p8),
        .tap_p14_o (tap_p14)
    );

    // The first 16 words come straight from the loaded block; later words
    // overwrite their own slot, so the window always holds W[t-16..t-1].
    assign w_run = (t_q < 7'd16) ? tap_p : rotl1(tap_p3 ^ tap_p8 ^ tap_p14 ^ tap_p);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        buf_we    = 1'b0;
        buf_waddr = cnt_q;
        buf_wdata = load_word;
        case (state_q)
            ST_LOAD: begin
                if (load) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_RUN;
                        t_d     = '0;
                    end
                end
            end
            ST_RUN: begin
                if (next) begin
                    buf_we    = 1'b1;
                    buf_waddr = t_q[3:0];
                    buf_wdata = w_run;
                    t_d       = t_q + 7'd1;
                    if (t_q == 7'(ROUNDS - 1)) begin
                        state_d = ST_DONE;
                        t_d     = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    assign run         = (state_q == ST_RUN);
    assign load_ready  = (state_q == ST_LOAD);
    assign w_valid     = run;
    assign w           = run ? w_run : '0;
    assign w_index     = run ? t_q : '0;
    assign feed        = run && (t_q == 7'd0);
    assign last        = run && (t_q == 7'(ROUNDS - 1));
    assign done        = (state_q == ST_DONE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sha1_wsched.sv
// Bench for sha1_wsched: driver tasks load blocks and pace next, a negedge monitor
// checks every accepted word against a queue filled by a reference schedule model.
module tb_sha1_wsched;
    import sha1_pkg::*;

    localparam int ROUNDS = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] load_word;
    logic        load_ready;
    logic [31:0] w;
    logic        w_valid;
    logic [6:0]  w_index;
    logic        feed;
    logic        last;
    logic        next;
    logic        done;
    sha1_state_e state_dbg;

    always #5 clk = ~clk;

    sha1_wsched #(.ROUNDS(ROUNDS)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_word   (load_word),
        .load_ready  (load_ready),
        .w           (w),
        .w_valid     (w_valid),
        .w_index     (w_index),
        .feed        (feed),
        .last        (last),
        .next        (next),
        .done        (done),
        .state_dbg_o (state_dbg)
    );

    int          total = 0;
    int          bad = 0;
    logic [38:0] exp_q[$];
    logic [31:0] seen_w [ROUNDS];
    logic [31:0] blk [16];
    int          acc_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference schedule: straight W[0..79] array, no circular buffer.
    task automatic push_expected();
        logic [31:0] m [ROUNDS];
        logic [31:0] x;
        for (int t = 0; t < ROUNDS; t++) begin
            if (t < 16) begin
                m[t] = blk[t];
            end else begin
                x    = m[t-3] ^ m[t-8] ^ m[t-14] ^ m[t-16];
                m[t] = {x[30:0], x[31]};
            end
            exp_q.push_back({7'(t), m[t]});
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
    endtask

    task automatic set_fips2();
        blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566;
        blk[3]  = 32'h64656667; blk[4]  = 32'h65666768; blk[5]  = 32'h66676869;
        blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b; blk[8]  = 32'h696a6b6c;
        blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
        blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000;
        blk[15] = 32'h00000000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load  = 1'b0;
        next  = 1'b0;
        load_word = '0;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        check("reset_load_ready", 64'(load_ready), 64'd1);
        check("reset_w_valid",    64'(w_valid),    64'd0);
        check("reset_w",          64'(w),          64'd0);
        check("reset_done",       64'(done),       64'd0);
    endtask

    task automatic load_block(input bit illegal);
        push_expected();
        for (int i = 0; i < 16; i++) begin
            if (illegal && i == 5) begin
                next = 1'b1;
                load = 1'b0;
                tick();
            end
            load      = 1'b1;
            load_word = blk[i];
            next      = illegal && (i == 9);
            if (i == 0) check("load_ready_in_load", 64'(load_ready), 64'd1);
            tick();
        end
        load = 1'b0;
        next = 1'b0;
        check("first_w_valid", 64'(w_valid), 64'd1);
        check("first_feed",    64'(feed),    64'd1);
        check("first_w",       64'(w),       64'(blk[0]));
        check("first_index",   64'(w_index), 64'd0);
    endtask

    // mode 0: next held high, 1: next at ~30% duty, 2: next high with random load strobes.
    task automatic run_block(input int mode, input int stop_at);
        int cyc;
        cyc      = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < ROUNDS; i++) seen_w[i] = 'x;
        while (cyc < 2000) begin
            if (stop_at >= 0 && w_valid && int'(w_index) == stop_at) begin
                reset = 1'b0;
                next  = 1'b0;
                load  = 1'b0;
                exp_q.delete();
                tick();
                reset = 1'b1;
                check("midrst_load_ready", 64'(load_ready), 64'd1);
                check("midrst_w_valid",    64'(w_valid),    64'd0);
                for (int i = 0; i < 16; i++)
                    check("midrst_buf_zero", 64'(u_dut.u_wbuf.mem_q[i]), 64'd0);
                tick();
                check("midrst_no_done", 64'(done_cnt), 64'd0);
                return;
            end
            case (mode)
                1:       next = ($urandom_range(0, 99) < 30);
                2: begin
                    next      = 1'b1;
                    load      = $urandom_range(0, 1) == 1;
                    load_word = $urandom;
                end
                default: next = 1'b1;
            endcase
            tick();
            cyc++;
            if (done) break;
        end
        load = 1'b0;
        next = 1'b0;
        if (cyc >= 2000) check("run_timeout", 64'd1, 64'd0);
        check("accept_count", 64'(acc_cnt), 64'(ROUNDS));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        tick();
        check("ready_after_done", 64'(load_ready), 64'd1);
        check("done_once", 64'(done_cnt), 64'd1);
    endtask

    task automatic abc_hand_checks(input string tag);
        check({tag, "_W0"},  64'(seen_w[0]),  64'h6162_6380);
        check({tag, "_W16"}, 64'(seen_w[16]), 64'hC2C4_C700);
        check({tag, "_W17"}, 64'(seen_w[17]), 64'h0000_0000);
        check({tag, "_W18"}, 64'(seen_w[18]), 64'h0000_0030);
        check({tag, "_W19"}, 64'(seen_w[19]), 64'h8589_8E01);
    endtask

    // Monitor: pops the scoreboard on every accepted word, tracks done timing and stalls.
    initial begin
        logic        done_exp;
        logic        hold_v;
        logic [31:0] hold_w;
        logic [6:0]  hold_idx;
        logic [38:0] e;
        done_exp = 1'b0;
        hold_v   = 1'b0;
        hold_w   = '0;
        hold_idx = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 || reset === 1'b0) begin
                check("done_timing", 64'(done), 64'(done_exp));
                if (done) done_cnt++;
                if (w_valid) begin
                    if (hold_v) begin
                        check("stall_w_stable",     64'(w),       64'(hold_w));
                        check("stall_index_stable", 64'(w_index), 64'(hold_idx));
                    end
                    if (next) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", 64'(w_index), 64'h7f);
                        end else begin
                            e = exp_q.pop_front();
                            check("w_word",  64'(w),       64'(e[31:0]));
                            check("w_index", 64'(w_index), 64'(e[38:32]));
                            check("feed",    64'(feed),    64'(e[38:32] == 7'd0));
                            check("last",    64'(last),    64'(e[38:32] == 7'(ROUNDS - 1)));
                        end
                        seen_w[w_index] = w;
                        acc_cnt++;
                    end
                    hold_v   = !next;
                    hold_w   = w;
                    hold_idx = w_index;
                end else begin
                    check("idle_outputs", 64'({w, w_index, feed, last}), 64'd0);
                    hold_v = 1'b0;
                end
                done_exp = w_valid && next && last && reset;
            end
        end
    end

    initial begin
        reset = 1'b0;
        load = 1'b0;
        next = 1'b0;
        load_word = '0;

        do_reset();

        set_abc();
        load_block(1'b0);
        run_block(0, -1);
        abc_hand_checks("abc_full");

        load_block(1'b0);
        run_block(1, -1);
        abc_hand_checks("abc_stall");

        load_block(1'b1);
        run_block(2, -1);
        abc_hand_checks("abc_illegal");

        load_block(1'b0);
        run_block(0, 40);
        set_abc();
        load_block(1'b0);
        run_block(0, -1);
        abc_hand_checks("abc_after_rst");

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(1'b0);
        run_block(0, -1);
        set_fips2();
        load_block(1'b0);
        run_block(1, -1);
        check("fips_W0",  64'(seen_w[0]),  64'h6162_6364);
        check("fips_W15", 64'(seen_w[15]), 64'h0000_0000);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
